// File: rtl/event_stretcher.sv
// Per-channel event-to-level stretcher: every accepted single-cycle event yields one
// HOLD_CYCLES-wide high level followed by a GAP_CYCLES-wide forced-low gap.
module event_stretcher #(
    parameter int CHANNELS    = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] event_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] overflow_o
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("event_stretcher: HOLD_CYCLES and GAP_CYCLES must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        state_t          state, state_next;
        logic [CW-1:0]   count, count_next;
        logic            pending, pending_next;
        logic            drop;
        logic            level, busy, overflow;

        always_comb begin
            state_next   = state;
            count_next   = count;
            pending_next = pending;
            drop         = 1'b0;
            unique case (state)
                IDLE: begin
                    pending_next = 1'b0;
                    if (event_i[c]) begin
                        state_next = HIGH;
                        count_next = HOLD_LOAD;
                    end
                end
                HIGH: begin
                    if (count == '0) begin
                        state_next = GAP;
                        count_next = GAP_LOAD;
                    end else begin
                        count_next = count - CW'(1);
                    end
                    if (event_i[c]) begin
                        if (pending) drop = 1'b1;
                        else         pending_next = 1'b1;
                    end
                end
                GAP: begin
                    if (count != '0) begin
                        count_next = count - CW'(1);
                        if (event_i[c]) begin
                            if (pending) drop = 1'b1;
                            else         pending_next = 1'b1;
                        end
                    // Final gap cycle: the queued event is served and a
                    // simultaneous new event takes its slot, so nothing is lost.
                    end else if (pending) begin
                        state_next   = HIGH;
                        count_next   = HOLD_LOAD;
                        pending_next = event_i[c];
                    end else if (event_i[c]) begin
                        state_next = HIGH;
                        count_next = HOLD_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    count_next   = '0;
                    pending_next = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state    <= IDLE;
                count    <= '0;
                pending  <= 1'b0;
                level    <= 1'b0;
                busy     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                state    <= state_next;
                count    <= count_next;
                pending  <= pending_next;
                level    <= (state_next == HIGH);
                busy     <= (state_next != IDLE);
                overflow <= drop;
            end
        end

        assign level_o[c]    = level;
        assign busy_o[c]     = busy;
        assign overflow_o[c] = overflow;
    end

endmodule

// File: tb/tb_event_stretcher.sv
// Bench for event_stretcher: two 2-channel instances (4/2 and 1/1) checked every cycle
// against a schedule-of-start-times reference model.
module tb_event_stretcher;

    localparam int HA = 4;
    localparam int GA = 2;
    localparam int HB = 1;
    localparam int GB = 1;
    localparam int NONE = -1000;

    logic       clk;
    logic       rst;
    logic [1:0] ev_a, ev_b;
    logic [1:0] lvl_a, busy_a, ovf_a;
    logic [1:0] lvl_b, busy_b, ovf_b;

    event_stretcher #(.CHANNELS(2), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clk_i(clk), .rst_i(rst), .event_i(ev_a),
        .level_o(lvl_a), .busy_o(busy_a), .overflow_o(ovf_a)
    );

    event_stretcher #(.CHANNELS(2), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk_i(clk), .rst_i(rst), .event_i(ev_b),
        .level_o(lvl_b), .busy_o(busy_b), .overflow_o(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    bit checking = 1'b0;

    // Model: start cycle of the most recent and the one before it per channel.
    int last_s[2][2];
    int prev_s[2][2];
    bit ovf_m[2][2];

    function automatic int hold_of(input int d);
        return (d == 0) ? HA : HB;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? GA : GB;
    endfunction

    function automatic bit in_win(input int s, input int cyc, input int w);
        return (s <= cyc) && (cyc < s + w);
    endfunction

    task automatic chk(input string tag, input int d, input int c, input logic got, input logic exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s dut%0d ch%0d cycle=%0d got=%b expected=%b", tag, d, c, t, got, exp);
        end
    endtask

    task automatic model_update(input int d, input bit r, input logic [1:0] ev);
        int h, g;
        h = hold_of(d);
        g = gap_of(d);
        for (int c = 0; c < 2; c++) begin
            ovf_m[d][c] = 1'b0;
            if (r) begin
                last_s[d][c] = NONE;
                prev_s[d][c] = NONE;
            end else if (ev[c]) begin
                if (last_s[d][c] > t + 1) begin
                    ovf_m[d][c] = 1'b1;
                end else begin
                    prev_s[d][c] = last_s[d][c];
                    last_s[d][c] = (t + 1 > last_s[d][c] + h + g) ? t + 1 : last_s[d][c] + h + g;
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [1:0] ea, input logic [1:0] eb);
        @(posedge clk);
        #1;
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    int  h, w;
                    bit  el, eb2;
                    h   = hold_of(d);
                    w   = h + gap_of(d);
                    el  = in_win(prev_s[d][c], t, h) || in_win(last_s[d][c], t, h);
                    eb2 = in_win(prev_s[d][c], t, w) || in_win(last_s[d][c], t, w);
                    chk("level",    d, c, (d == 0) ? lvl_a[c]  : lvl_b[c],  el);
                    chk("busy",     d, c, (d == 0) ? busy_a[c] : busy_b[c], eb2);
                    chk("overflow", d, c, (d == 0) ? ovf_a[c]  : ovf_b[c],  ovf_m[d][c]);
                end
            end
        end
        model_update(0, r, ea);
        model_update(1, r, eb);
        rst  = r;
        ev_a = ea;
        ev_b = eb;
        t++;
        checking = 1'b1;
    endtask

    // Channel-0 pulses on instance A at up to three offsets, optional reset at rst_at.
    task automatic run_a(input int p0, input int p1, input int p2, input int len, input int rst_at);
        for (int i = 0; i < len; i++) begin
            step(i == rst_at, {1'b0, (i == p0) || (i == p1) || (i == p2)}, 2'b00);
        end
    endtask

    initial begin
        rst  = 1'b1;
        ev_a = 2'b00;
        ev_b = 2'b00;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                last_s[d][c] = NONE;
                prev_s[d][c] = NONE;
                ovf_m[d][c]  = 1'b0;
            end
        end

        // Reset with events toggling, then idle.
        step(1'b1, 2'b11, 2'b11);
        step(1'b1, 2'b00, 2'b10);
        step(1'b1, 2'b11, 2'b01);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b00);

        run_a(0, -1, -1, 10, -1);   // single event
        run_a(0,  2, -1, 16, -1);   // queued event
        run_a(0,  2,  3, 16, -1);   // overflow on third pulse
        run_a(0,  6, -1, 14, -1);   // event in final gap cycle
        run_a(0,  2, -1, 12,  3);   // reset mid-operation

        // Instance B: ch0 held high 6 cycles, ch1 single pulse at cycle 3.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b00, {(i == 3), (i < 6)});
        end

        // Random traffic with varying density and rare resets.
        for (int blk = 0; blk < 10; blk++) begin
            int p;
            p = $urandom_range(5, 90);
            for (int i = 0; i < 200; i++) begin
                logic [1:0] ea, eb;
                bit r;
                r  = ($urandom_range(0, 149) == 0);
                ea = {($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p)};
                eb = {($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p)};
                step(r, ea, eb);
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
